// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between a data-memory initiator and the responder.
//   req_valid/req_ready  : request handshake
//   req_we               : 1 = store, 0 = load
//   req_size             : 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned         : 1 = zero-extend load data, 0 = sign-extend
//   req_addr             : byte address
//   req_wdata            : right-aligned store data
//   resp_valid/resp_ready: response handshake
//   resp_rdata           : extended load data (0 for stores and errors)
//   resp_err             : misaligned, out of range or reserved size
// Modports: master = initiator side, slave = responder side.
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Word-organised data memory with a fixed-latency valid/ready request and
// response handshake. Stores commit on the accepting edge; loads read the word
// on the accepting edge and present the extended byte/half/word LATENCY edges
// later (the accepting edge counts as the first), holding it until resp_ready.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset (memory contents are kept)
//   bus   : dmem_responder_if.slave request/response bundle
// Parameters:
//   DEPTH   : number of 32-bit words (power of two, >= 4)
//   LATENCY : edges from accept to response valid (1..15)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        req_ready_reg;
  logic        resp_valid_reg;
  logic        we_reg;
  logic        uns_reg;
  logic        err_reg;
  logic [1:0]  size_reg;
  logic [1:0]  lane_reg;
  logic [31:0] rd_word_reg;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_lane;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  // req_ready_reg is only high in IDLE; reset blocks acceptance on its edge.
  assign accept   = bus.req_valid && req_ready_reg && !reset;
  assign word_idx = bus.req_addr[AW+1:2];

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if (bus.req_addr[31:2] >= 30'(DEPTH)) begin
      req_err = 1'b1;
    end
  end

  // Byte-lane enables and lane-replicated store data (little-endian lanes).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign wr_be[gi] = (bus.req_size == 2'b10) ||
                       (bus.req_size == 2'b01 && bus.req_addr[1] == LANE[1]) ||
                       (bus.req_size == 2'b00 && bus.req_addr[1:0] == LANE);
    assign wr_lane[8*gi +: 8] =
        (bus.req_size == 2'b00) ? bus.req_wdata[7:0] :
        (bus.req_size == 2'b01) ? bus.req_wdata[8*(gi % 2) +: 8] :
                                  bus.req_wdata[8*gi +: 8];
  end

  // Storage: no reset so the array maps onto block RAM; the read word is
  // registered at accept so later input changes cannot affect the response.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (bus.req_we && !req_err) begin
        for (int i = 0; i < 4; i++) begin
          if (wr_be[i]) begin
            mem[word_idx][8*i +: 8] <= wr_lane[8*i +: 8];
          end
        end
      end
      rd_word_reg <= mem[word_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      we_reg         <= 1'b0;
      uns_reg        <= 1'b0;
      err_reg        <= 1'b0;
      size_reg       <= 2'b00;
      lane_reg       <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            we_reg        <= bus.req_we;
            uns_reg       <= bus.req_unsigned;
            err_reg       <= req_err;
            size_reg      <= bus.req_size;
            lane_reg      <= bus.req_addr[1:0];
            req_ready_reg <= 1'b0;
            if (LATENCY == 1) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd1) begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          // Return to IDLE only; the next accept is one cycle later at best.
          if (bus.resp_ready) begin
            state_reg      <= IDLE;
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg      <= IDLE;
          resp_valid_reg <= 1'b0;
          req_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  // Lane select and extension work purely on registered state, so the
  // response stays stable for as long as it is held in RESP.
  always_comb begin
    byte_sel = rd_word_reg[7:0];
    case (lane_reg)
      2'd0:    byte_sel = rd_word_reg[7:0];
      2'd1:    byte_sel = rd_word_reg[15:8];
      2'd2:    byte_sel = rd_word_reg[23:16];
      default: byte_sel = rd_word_reg[31:24];
    endcase
    half_sel = lane_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];
    case (size_reg)
      2'b00:   load_ext = {{24{~uns_reg & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns_reg & half_sel[15]}}, half_sel};
      default: load_ext = rd_word_reg;
    endcase
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_valid_reg & err_reg;
  assign bus.resp_rdata = (resp_valid_reg && !err_reg && !we_reg) ? load_ext : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder: a LATENCY=2 instance for data paths,
// errors, backpressure and reset, and a LATENCY=1 instance for back-to-back
// throughput. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  dmem_responder_if bus2 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the LATENCY=2 instance; request inputs are
  // scrambled right after acceptance to show they were captured.
  task automatic txn2(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    check_bit({tag, " req_ready idle"}, bus2.req_ready, 1'b1);
    bus2.req_valid    = 1'b1;
    bus2.req_we       = we;
    bus2.req_size     = size;
    bus2.req_unsigned = uns;
    bus2.req_addr     = addr;
    bus2.req_wdata    = wdata;
    step();
    bus2.req_valid    = 1'b0;
    bus2.req_we       = ~we;
    bus2.req_size     = size ^ 2'b01;
    bus2.req_unsigned = ~uns;
    bus2.req_addr     = addr ^ 32'h0000_0004;
    bus2.req_wdata    = ~wdata;
    check_bit({tag, " resp_valid wait"}, bus2.resp_valid, 1'b0);
    check_bit({tag, " req_ready wait"}, bus2.req_ready, 1'b0);
    step();
    check_bit({tag, " resp_valid"}, bus2.resp_valid, 1'b1);
    check({tag, " rdata"}, bus2.resp_rdata, exp_rdata);
    check_bit({tag, " err"}, bus2.resp_err, exp_err);
    bus2.resp_ready = 1'b1;
    step();
    bus2.resp_ready = 1'b0;
    check_bit({tag, " resp_valid done"}, bus2.resp_valid, 1'b0);
    check_bit({tag, " req_ready done"}, bus2.req_ready, 1'b1);
    $display("txn %s: we=%b size=%b uns=%b addr=0x%08h wdata=0x%08h exp_rdata=0x%08h exp_err=%b",
             tag, we, size, uns, addr, wdata, exp_rdata, exp_err);
  endtask

  // Back-to-back transaction on the LATENCY=1 instance: req_valid and
  // resp_ready stay high, so an accept can occur only every second edge.
  task automatic txn1(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    bus1.req_valid    = 1'b1;
    bus1.req_we       = we;
    bus1.req_size     = size;
    bus1.req_unsigned = uns;
    bus1.req_addr     = addr;
    bus1.req_wdata    = wdata;
    check_bit({tag, " req_ready"}, bus1.req_ready, 1'b1);
    step();
    check_bit({tag, " resp_valid"}, bus1.resp_valid, 1'b1);
    check({tag, " rdata"}, bus1.resp_rdata, exp_rdata);
    check_bit({tag, " err"}, bus1.resp_err, exp_err);
    check_bit({tag, " req_ready busy"}, bus1.req_ready, 1'b0);
    step();
    check_bit({tag, " resp_valid gap"}, bus1.resp_valid, 1'b0);
    check_bit({tag, " req_ready gap"}, bus1.req_ready, 1'b1);
    $display("txn1 %s: we=%b size=%b uns=%b addr=0x%08h exp_rdata=0x%08h exp_err=%b",
             tag, we, size, uns, addr, exp_rdata, exp_err);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_size = 2'b00;
    bus2.req_unsigned = 1'b0; bus2.req_addr = 32'd0; bus2.req_wdata = 32'd0;
    bus2.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_size = 2'b00;
    bus1.req_unsigned = 1'b0; bus1.req_addr = 32'd0; bus1.req_wdata = 32'd0;
    bus1.resp_ready = 1'b0;

    // Reset state
    step();
    step();
    check_bit("reset req_ready", bus2.req_ready, 1'b1);
    check_bit("reset resp_valid", bus2.resp_valid, 1'b0);
    check("reset rdata", bus2.resp_rdata, 32'd0);
    check_bit("reset err", bus2.resp_err, 1'b0);
    check_bit("reset l1 req_ready", bus1.req_ready, 1'b1);
    check_bit("reset l1 resp_valid", bus1.resp_valid, 1'b0);
    $display("reset applied and checked");
    reset = 1'b0;

    // Word round-trip and byte lanes
    txn2("st_w_0",      1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b0);
    txn2("st_w_10",     1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    txn2("ld_w_10",     1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
    txn2("st_b_12",     1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'h1234_5680, 32'h0000_0000, 1'b0);
    txn2("ld_sb_12",    1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0,         32'hFFFF_FF80, 1'b0);
    txn2("ld_uh_12",    1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_DE80, 1'b0);
    txn2("ld_sh_12",    1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'hFFFF_DE80, 1'b0);
    txn2("ld_ub_13",    1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0);
    txn2("ld_w_10b",    1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDE80_BEEF, 1'b0);

    // Errors
    txn2("ld_w_11_mis", 1'b0, 2'b10, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1);
    txn2("st_w_oor",    1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hCAFE_BABE, 32'h0000_0000, 1'b1);
    txn2("ld_w_0_keep", 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0);
    txn2("ld_rsv",      1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1);
    txn2("st_rsv",      1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1);
    txn2("st_h_11_mis", 1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_5555, 32'h0000_0000, 1'b1);
    txn2("ld_w_10_keep",1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDE80_BEEF, 1'b0);
    txn2("st_h_top",    1'b1, 2'b01, 1'b0, 32'h0000_03FE, 32'hFFFF_ABCD, 32'h0000_0000, 1'b0);
    txn2("ld_sh_top",   1'b0, 2'b01, 1'b0, 32'h0000_03FE, 32'h0,         32'hFFFF_ABCD, 1'b0);
    txn2("ld_b_oor",    1'b0, 2'b00, 1'b1, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1);

    // Backpressure: a competing store stays presented while the response is held
    check_bit("bp req_ready idle", bus2.req_ready, 1'b1);
    bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_size = 2'b10;
    bus2.req_unsigned = 1'b0; bus2.req_addr = 32'h0000_0010;
    step();
    bus2.req_we = 1'b1; bus2.req_addr = 32'h0000_0000; bus2.req_wdata = 32'h0;
    step();
    check_bit("bp resp_valid", bus2.resp_valid, 1'b1);
    check("bp rdata", bus2.resp_rdata, 32'hDE80_BEEF);
    for (int i = 0; i < 5; i++) begin
      step();
      check_bit("bp hold resp_valid", bus2.resp_valid, 1'b1);
      check("bp hold rdata", bus2.resp_rdata, 32'hDE80_BEEF);
      check_bit("bp hold err", bus2.resp_err, 1'b0);
      check_bit("bp hold req_ready", bus2.req_ready, 1'b0);
      $display("backpressure cycle %0d: resp_valid=%b rdata=0x%08h req_ready=%b",
               i, bus2.resp_valid, bus2.resp_rdata, bus2.req_ready);
    end
    bus2.req_valid = 1'b0;
    bus2.resp_ready = 1'b1;
    step();
    bus2.resp_ready = 1'b0;
    check_bit("bp release resp_valid", bus2.resp_valid, 1'b0);
    check_bit("bp release req_ready", bus2.req_ready, 1'b1);
    txn2("ld_w_0_nobp", 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, 1'b0);

    // Reset during WAIT: the pending load never responds
    bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_size = 2'b10;
    bus2.req_addr = 32'h0000_0010;
    step();
    bus2.req_valid = 1'b0;
    check_bit("rst_wait in wait", bus2.resp_valid, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_bit("rst_wait req_ready", bus2.req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_bit("rst_wait no resp", bus2.resp_valid, 1'b0);
      step();
    end
    $display("reset during wait checked");

    // Reset during RESP after a store: store stays committed
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_size = 2'b10;
    bus2.req_addr = 32'h0000_0020; bus2.req_wdata = 32'h2222_2222;
    step();
    bus2.req_valid = 1'b0;
    step();
    check_bit("rst_resp in resp", bus2.resp_valid, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_bit("rst_resp dropped", bus2.resp_valid, 1'b0);
    txn2("ld_w_20", 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 32'h2222_2222, 1'b0);

    // No accept on an edge with reset high
    reset = 1'b1;
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_size = 2'b10;
    bus2.req_addr = 32'h0000_0000; bus2.req_wdata = 32'h3333_3333;
    step();
    reset = 1'b0;
    bus2.req_valid = 1'b0;
    check_bit("rst_acc req_ready", bus2.req_ready, 1'b1);
    step();
    check_bit("rst_acc no resp", bus2.resp_valid, 1'b0);
    txn2("ld_w_0_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, 1'b0);

    // LATENCY = 1 back-to-back
    bus1.resp_ready = 1'b1;
    txn1("l1_st_w_8",  1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0);
    txn1("l1_ld_w_8",  1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         32'hA5A5_A5A5, 1'b0);
    txn1("l1_ld_sb_9", 1'b0, 2'b00, 1'b0, 32'h0000_0009, 32'h0,         32'hFFFF_FFA5, 1'b0);
    txn1("l1_ld_uh_a", 1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0,         32'h0000_A5A5, 1'b0);
    txn1("l1_ld_w_9",  1'b0, 2'b10, 1'b0, 32'h0000_0009, 32'h0,         32'h0000_0000, 1'b1);
    bus1.req_valid  = 1'b0;
    bus1.resp_ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, giving the number of 32-bit words of storage (power of two, at least 4).
REQ-002 SHALL have parameter LATENCY, default 2, giving the clock edges from request acceptance to response valid (1 to 15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-009 SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend load data, 0 = sign-extend load data.
REQ-010 SHALL have port req_addr, input, 32 bits: byte address.
REQ-011 SHALL have port req_wdata, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port resp_valid, output, 1 bit: a response is presented.
REQ-013 SHALL have port resp_ready, input, 1 bit: the initiator accepts the response.
REQ-014 SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err, output, 1 bit: the request was misaligned, out of range, or of reserved size.

Function
REQ-016 SHALL accept a request on any rising edge where req_valid and req_ready are both 1.
REQ-017 SHALL implement a state machine with states IDLE, WAIT, and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 SHALL make these transitions: IDLE goes to WAIT on accept when LATENCY > 1; IDLE goes directly to RESP on accept when LATENCY = 1; WAIT goes to RESP when its down-counter (loaded with LATENCY-1) reaches 1; RESP goes to IDLE on the edge where resp_ready = 1.
REQ-019 SHALL assert resp_valid exactly LATENCY edges after the accepting edge, and hold it with resp_rdata and resp_err stable until resp_ready = 1.
REQ-020 SHALL capture all request fields at acceptance; changes on the request inputs after that SHALL have no effect.
REQ-021 SHALL flag an error when any of the following holds: req_size = 11; half access with addr[0] != 0; word access with addr[1:0] != 0; or addr[31:2] >= DEPTH.
REQ-022 SHALL, for an errored request, leave memory unchanged and respond with resp_err = 1 and resp_rdata = 0.
REQ-023 SHALL commit a non-errored store on the accepting edge, using little-endian byte lanes selected by addr[1:0], and write only the addressed bytes.
REQ-024 SHALL form load data from the word contents at accept time, select the addressed byte or half, extend it per req_unsigned, and register it for the response.
REQ-025 SHALL give a store immediately following another store to the same address the later data; a load after a store SHALL return the stored data.
REQ-026 SHALL hold the response in RESP while resp_ready = 0, for an unbounded number of cycles, accepting no new request.
REQ-027 SHALL return to IDLE with req_ready = 1 on the cycle after the edge where resp_ready = 1; there SHALL be no same-cycle re-accept, giving a maximum throughput of one request per LATENCY+1 cycles.
REQ-028 SHALL ignore resp_ready outside RESP.

Reset
REQ-029 SHALL, on reset = 1 at a rising edge, enter IDLE with req_ready = 1 on the following cycle, and set resp_valid = 0, resp_rdata = 0, and resp_err = 0.
REQ-030 SHALL, on reset mid-transaction in WAIT or RESP, discard the pending response with none delivered; a store already committed SHALL remain in memory.
REQ-031 SHALL NOT clear memory contents on reset, and SHALL accept no request on an edge where reset = 1.

Verification
REQ-032 SHALL be verified for word round-trip: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid rising 2 edges after each accept.
REQ-033 SHALL be verified for byte lanes: after the word round-trip, store byte 0x80 at 0x12, then load signed byte at 0x12 -> 0xFFFFFF80; load unsigned half at 0x12 -> 0x0000DE80; load word at 0x10 -> 0xDE80BEEF.
REQ-034 SHALL be verified for errors: load word at 0x11 -> resp_err = 1 and rdata = 0; store to (DEPTH*4) -> resp_err = 1 with memory unchanged; size = 11 -> resp_err = 1.
REQ-035 SHALL be verified for backpressure: hold resp_ready = 0 for 5 cycles -> resp_valid, rdata, and err stable and req_ready = 0 throughout; raise resp_ready -> req_ready = 1 on the next cycle.
REQ-036 SHALL be verified for reset mid-operation: accept a load, assert reset during WAIT -> no resp_valid ever for that load; req_ready = 1 after reset deasserts.
REQ-037 SHALL be verified with LATENCY = 1: back-to-back requests with resp_ready held at 1 -> one accept every 2 cycles, each response valid 1 edge after its accept.
